title_editor: RTL and testbench

//  Builds a 12-character title from a stream of ASCII characters and presents it as

---
 rtl/title_editor.sv | 154 +++++++++++++++
 tb/tb_title_editor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/title_editor.sv
// Title edit buffer with commit-to-display and a 12-cycle clear sweep.
// Characters are mapped to glyph ROM base addresses when they are written.
module title_editor #(
    parameter int unsigned GLYPH_ROWS = 8,
    parameter int unsigned NUM_CHARS  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_ascii,
    output logic       char_ready,
    input  logic       backspace,
    input  logic       clear,
    input  logic       commit,
    output logic [8:0] char1,
    output logic [8:0] char2,
    output logic [8:0] char3,
    output logic [8:0] char4,
    output logic [8:0] char5,
    output logic [8:0] char6,
    output logic [8:0] char7,
    output logic [8:0] char8,
    output logic [8:0] char9,
    output logic [8:0] char10,
    output logic [8:0] char11,
    output logic [8:0] char12,
    output logic [3:0] cursor,
    output logic       full,
    output logic       bad_char
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [3:0] LAST  = 4'(NUM_CHARS - 1);

    logic [0:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cursor_q, cursor_d;
    logic       bad_q, bad_d;
    logic [8:0] buf_q [NUM_CHARS];
    logic [8:0] buf_d [NUM_CHARS];
    logic [8:0] chr_q [NUM_CHARS];
    logic [8:0] chr_d [NUM_CHARS];

    logic [5:0] glyph;
    logic       glyph_ok;
    logic [8:0] glyph_addr;

    always_comb begin
        glyph    = '0;
        glyph_ok = 1'b0;
        if (char_ascii == 8'h20) begin
            glyph_ok = 1'b1;
        end else if (char_ascii >= 8'h41 && char_ascii <= 8'h5A) begin
            glyph    = 6'(char_ascii - 8'h40);
            glyph_ok = 1'b1;
        end else if (char_ascii >= 8'h61 && char_ascii <= 8'h7A) begin
            glyph    = 6'(char_ascii - 8'h60);
            glyph_ok = 1'b1;
        end else if (char_ascii >= 8'h30 && char_ascii <= 8'h39) begin
            // '0' (0x30) lands on glyph 27
            glyph    = 6'(char_ascii - 8'd21);
            glyph_ok = 1'b1;
        end
    end

    assign glyph_addr = 9'(glyph) * 9'(GLYPH_ROWS);

    assign full       = (cursor_q == 4'(NUM_CHARS));
    assign char_ready = rst_n && (state_q == IDLE) && !full
                        && !clear && !commit && !backspace;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cursor_d = cursor_q;
        bad_d    = 1'b0;
        buf_d    = buf_q;
        chr_d    = chr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end else if (commit) begin
                    chr_d = buf_q;
                end else if (backspace) begin
                    if (cursor_q != '0) begin
                        cursor_d = cursor_q - 4'd1;
                        for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                            if (4'(i) == cursor_q - 4'd1) buf_d[i] = '0;
                        end
                    end
                end else if (char_valid && char_ready) begin
                    if (glyph_ok) begin
                        cursor_d = cursor_q + 4'd1;
                        for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                            if (4'(i) == cursor_q) buf_d[i] = glyph_addr;
                        end
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                    if (4'(i) == idx_q) buf_d[i] = '0;
                end
                if (idx_q == LAST) begin
                    idx_d    = '0;
                    cursor_d = '0;
                    state_d  = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cursor_q <= '0;
            bad_q    <= 1'b0;
            buf_q    <= '{default: '0};
            chr_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cursor_q <= cursor_d;
            bad_q    <= bad_d;
            buf_q    <= buf_d;
            chr_q    <= chr_d;
        end
    end

    assign cursor   = cursor_q;
    assign bad_char = bad_q;
    assign char1    = chr_q[0];
    assign char2    = chr_q[1];
    assign char3    = chr_q[2];
    assign char4    = chr_q[3];
    assign char5    = chr_q[4];
    assign char6    = chr_q[5];
    assign char7    = chr_q[6];
    assign char8    = chr_q[7];
    assign char9    = chr_q[8];
    assign char10   = chr_q[9];
    assign char11   = chr_q[10];
    assign char12   = chr_q[11];

endmodule

// File: tb/tb_title_editor.sv
// Directed bench for title_editor with hand-computed glyph addresses.
module tb_title_editor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_ascii = 8'h00;
    logic       char_ready;
    logic       backspace = 1'b0;
    logic       clear = 1'b0;
    logic       commit = 1'b0;
    logic [8:0] char1, char2, char3, char4, char5, char6;
    logic [8:0] char7, char8, char9, char10, char11, char12;
    logic [3:0] cursor;
    logic       full;
    logic       bad_char;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    title_editor #(.GLYPH_ROWS(8), .NUM_CHARS(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .char_valid(char_valid), .char_ascii(char_ascii), .char_ready(char_ready),
        .backspace(backspace), .clear(clear), .commit(commit),
        .char1(char1), .char2(char2), .char3(char3), .char4(char4),
        .char5(char5), .char6(char6), .char7(char7), .char8(char8),
        .char9(char9), .char10(char10), .char11(char11), .char12(char12),
        .cursor(cursor), .full(full), .bad_char(bad_char)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one character for one cycle; acc reports whether it handshook.
    task automatic offer(input logic [7:0] c, output bit acc);
        char_valid = 1'b1;
        char_ascii = c;
        #1 acc = char_ready;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic type_str(input string s);
        bit acc;
        for (int i = 0; i < s.len(); i++) offer(s[i], acc);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Counts cycles with char_ready low after a clear pulse, bounded.
    task automatic do_clear(input string tag);
        int lows = 0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        while (!char_ready && lows < 30) begin
            tick();
            lows++;
        end
        check(tag, lows, 12);
    endtask

    initial begin
        bit acc;
        int hs;
        bit bad_seen;

        // Reset state
        #1;
        check("rst_ready", char_ready, 0);
        check("rst_cursor", cursor, 0);
        check("rst_char1", char1, 0);
        check("rst_bad", bad_char, 0);
        #12 rst_n = 1'b1;
        tick();
        check("idle_ready", char_ready, 1);

        // 1: PIANO
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            string s;
            s = "PIANO";
            offer(s[i], acc);
            hs += int'(acc);
        end
        check("piano_hs", hs, 5);
        check("piano_cursor", cursor, 5);
        check("precommit_char1", char1, 0);
        pulse_commit();
        check("piano_c1", char1, 128);
        check("piano_c2", char2, 72);
        check("piano_c3", char3, 8);
        check("piano_c4", char4, 112);
        check("piano_c5", char5, 120);
        check("piano_c6", char6, 0);
        check("piano_c12", char12, 0);

        // Lowercase, digit and space boundaries
        do_clear("clr_lc_sweep");
        type_str("z9 0");
        pulse_commit();
        check("lc_z", char1, 208);
        check("digit_9", char2, 288);
        check("space", char3, 0);
        check("digit_0", char4, 216);
        check("lc_c5_cleared", char5, 0);

        // 2: overflow
        do_clear("clr_full_sweep");
        hs = 0;
        bad_seen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            string s;
            s = "ABCDEFGHIJKLM";
            offer(s[i], acc);
            hs += int'(acc);
            bad_seen |= bad_char;
        end
        check("full_hs", hs, 12);
        check("full_flag", full, 1);
        check("full_cursor", cursor, 12);
        char_valid = 1'b1;
        char_ascii = "M";
        #1 check("full_ready_pending", char_ready, 0);
        char_ascii = 8'h23;
        tick();
        char_valid = 1'b0;
        bad_seen |= bad_char;
        check("full_no_bad", bad_seen, 0);
        pulse_commit();
        check("full_c1", char1, 8);
        check("full_c12", char12, 96);

        // 3: invalid char and backspace underflow
        do_clear("clr_bad_sweep");
        type_str("ABC");
        offer(8'h23, acc);
        check("bad_hs", acc, 1);
        check("bad_cursor", cursor, 3);
        check("bad_pulse", bad_char, 1);
        tick();
        check("bad_one_cycle", bad_char, 0);
        for (int k = 2; k >= -1; k--) begin
            backspace = 1'b1;
            tick();
            backspace = 1'b0;
            check("bs_cursor", cursor, (k < 0) ? 0 : k);
        end
        pulse_commit();
        check("bs_buf_c1", char1, 0);
        check("bs_buf_c3", char3, 0);

        // 4: clear keeps the committed title
        type_str("AB");
        pulse_commit();
        type_str("CD");
        do_clear("clr_keep_sweep");
        check("keep_cursor", cursor, 0);
        check("keep_c1", char1, 8);
        check("keep_c2", char2, 16);
        pulse_commit();
        check("blank_c1", char1, 0);
        check("blank_c3", char3, 0);

        // 5: priority
        type_str("Q");
        clear = 1'b1;
        commit = 1'b1;
        char_valid = 1'b1;
        char_ascii = "Z";
        #1 check("prio_ready", char_ready, 0);
        tick();
        clear = 1'b0;
        commit = 1'b0;
        check("prio_no_commit", char1, 0);
        hs = 0;
        while (!char_ready && hs < 30) begin
            tick();
            hs++;
        end
        check("prio_sweep", hs, 12);
        check("prio_cursor0", cursor, 0);
        tick();
        char_valid = 1'b0;
        check("prio_z_taken", cursor, 1);
        pulse_commit();
        check("prio_z_c1", char1, 208);
        backspace = 1'b1;
        char_valid = 1'b1;
        char_ascii = "Y";
        #1 check("bs_char_ready", char_ready, 0);
        tick();
        backspace = 1'b0;
        char_valid = 1'b0;
        check("bs_char_cursor", cursor, 0);

        // 6: reset mid-sweep
        type_str("A");
        pulse_commit();
        check("pre_rst_c1", char1, 8);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_c1", char1, 0);
        check("mid_rst_cursor", cursor, 0);
        check("mid_rst_ready", char_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", char_ready, 1);
        check("post_rst_cursor", cursor, 0);
        pulse_commit();
        check("post_rst_c1", char1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
